muldiv: RTL and testbench

Iterative multiply/divide unit for the RV32M extension; sits in the execute stage beside the combinational ALU and takes the instructions the ALU does not handle: OP opcode with funct7 = 0000001. One request at a time is accepted over a valid/ready handshake. The result is produced after a fixed 32-step radix-2 iteration, then held until the pipeline consumes it. A `kill` input lets the pipeline abandon an in-flight operation on flush.

---
 rtl/muldiv.sv | 156 +++++++++++++++
 tb/tb_muldiv.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step radix-2 shift-add / restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete at acceptance.
`timescale 1ns/1ps
module muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic                dz_q, dz_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_shift;
    logic                div_fits;
    logic [2*XLEN-1:0]   acc_step, prod;
    logic [XLEN-1:0]     div_sel, final_res;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign result     = result_q;

    // Operand magnitudes; MULHSU treats rs2 as unsigned, MULHU/DIVU/REMU are fully unsigned
    always_comb begin
        a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
        a_neg = a_sgn && rs1[XLEN-1];
        b_neg = b_sgn && rs2[XLEN-1];
        a_mag = a_neg ? XLEN'(-rs1) : rs1;
        b_mag = b_neg ? XLEN'(-rs2) : rs2;
    end

    // One iteration step plus sign correction / result selection for the final step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        if (f3_q[2]) begin
            acc_step = {div_fits ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0],
                        acc_q[XLEN-2:0], div_fits};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod    = neg_q ? (2*XLEN)'(-acc_step) : acc_step;
        div_sel = f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (f3_q[2]) begin
            final_res = neg_q ? XLEN'(-div_sel) : div_sel;
            if (dz_q && !f3_q[1]) final_res = '1;
        end else begin
            final_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_c;
    logic [XLEN-1:0] early_res_c;
    always_comb begin
        early_c     = funct3[2] && ((rs2 == '0) ||
                      (!funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1));
        early_res_c = (rs2 == '0) ? (funct3[1] ? rs1 : '1)
                                  : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && !kill) begin
                    f3_d    = funct3;
                    cnt_d   = '0;
                    neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    dz_d    = (rs2 == '0);
                    opnd_d  = funct3[2] ? b_mag : a_mag;
                    acc_d   = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                    state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_c) begin
                        state_d  = DONE;
                        result_d = early_res_c;
                    end
`endif
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (kill || resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vector table, handshake/kill/reset sequences,
// and randomized operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Architectural RV32M result, straight from the ISA definition
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                  : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`endif
        return 33;
    endfunction

    // Present a request for one cycle, then scramble the operand inputs
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    endtask

    // Called at the negedge after acceptance; counts cycles until resp_valid
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        start_op(f, a, b);
        wait_resp(lat);
        res = result;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        tbl[16];
        logic [31:0] res;
        int          lat;
        logic [31:0] held;

        tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFA};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        tbl[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        tbl[8]  = '{3'd5, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF};
        tbl[9]  = '{3'd6, 32'h1234_5678, 32'h0,         32'h1234_5678};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{3'd4, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF};
        tbl[13] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tbl[14] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

        #12;
        chk("reset_req_ready",  32'(req_ready),  32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_busy",       32'(busy),       32'd0);
        chk("reset_result",     result,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(tbl[i].f, tbl[i].a, tbl[i].b)));
            chk($sformatf("vec%0d_idle", i), 32'({req_ready, resp_valid, busy}), 32'b100);
        end

        // Consumer stalls for 10 cycles: result and req_ready held
        start_op(3'd5, 32'd100, 32'd7);
        chk("calc_busy", 32'({busy, req_ready}), 32'b10);
        wait_resp(lat);
        chk("hold_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_result", result, 32'd14);
            chk("hold_state", 32'({req_ready, resp_valid}), 32'b01);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("hold_release", 32'({req_ready, resp_valid, busy}), 32'b100);
        run_op(3'd0, 32'd12, 32'd11, res, lat);
        chk("after_hold_result", res, 32'd132);

        // Kill at CALC step 15
        start_op(3'd0, 32'd5, 32'd6);
        repeat (15) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_calc_state", 32'({req_ready, resp_valid, busy}), 32'b100);
        held = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) held = 1;
        end
        chk("kill_calc_no_resp", held, 32'd0);

        // Kill together with resp_ready in DONE
        start_op(3'd5, 32'd9, 32'd3);
        wait_resp(lat);
        chk("kill_done_valid", 32'(resp_valid), 32'd1);
        kill = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0; resp_ready = 1'b0;
        chk("kill_done_state", 32'({req_ready, resp_valid, busy}), 32'b100);

        // Kill in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        chk("kill_idle_no_accept", 32'({req_ready, busy}), 32'b10);

        // Reset at step 20 of a DIV
        start_op(3'd4, 32'd1000, 32'd7);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",  32'(resp_valid), 32'd0);
        chk("rst_mid_busy",   32'(busy),       32'd0);
        chk("rst_mid_result", result,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd4, 32'd1000, 32'd7, res, lat);
        chk("rst_after_result", res, 32'd142);
        chk("rst_after_latency", 32'(lat), 32'd33);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, res, lat);
            chk($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), res, ref_model(f, a, b));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(f, a, b)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
